// File: rtl/avmm_tile_mem_slave.sv
// avmm_tile_mem_slave: Avalon-MM tile exchange memory with pipelined reads and a clear engine.
// Optional doorbell/irq on CTRL bit1 when AVMM_TILE_MEM_DOORBELL_EN is defined.
module avmm_tile_mem_slave #(
    parameter int ADDR_W         = 10,
    parameter int READ_LATENCY   = 2,
    parameter bit CLEAR_ON_RESET = 1
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] in_bridge_slave_address,
    input  logic              in_bridge_slave_read,
    input  logic              in_bridge_slave_write,
    input  logic [31:0]       in_bridge_slave_writedata,
    input  logic [3:0]        in_bridge_slave_byteenable,
    input  logic              in_bridge_slave_burstcount,
    input  logic              in_bridge_slave_debugaccess,
    output logic              in_bridge_slave_waitrequest,
    output logic [31:0]       in_bridge_slave_readdata,
    output logic              in_bridge_slave_readdatavalid
`ifdef AVMM_TILE_MEM_DOORBELL_EN
    ,
    output logic              irq,
    input  logic              irq_ack
`endif
);
    localparam int AW    = ADDR_W - 2;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {READY, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           clr_q, clr_d;
    logic                    wait_q, wait_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [31:0]             dat_q [READ_LATENCY];
    logic [31:0]             dat_d [READ_LATENCY];
    logic [31:0]             mem [DEPTH];
    logic [AW-1:0]           idx;
    logic                    is_ctrl, acc_wr, acc_rd, ctrl_wr;
    logic                    unused;

    assign unused  = ^{in_bridge_slave_burstcount, in_bridge_slave_debugaccess, in_bridge_slave_address[1:0]};
    assign idx     = in_bridge_slave_address[ADDR_W-1:2];
    assign is_ctrl = idx == AW'(DEPTH - 1);
    assign acc_wr  = in_bridge_slave_write && !wait_q;
    // A simultaneous read+write is a write only
    assign acc_rd  = in_bridge_slave_read && !in_bridge_slave_write && !wait_q;
    assign ctrl_wr = acc_wr && is_ctrl && in_bridge_slave_byteenable[0];

`ifdef AVMM_TILE_MEM_DOORBELL_EN
    logic db_q, db_d;
    always_comb db_d = (ctrl_wr && in_bridge_slave_writedata[1]) ? 1'b1 : irq_ack ? 1'b0 : db_q;
    always_ff @(posedge clk_clk or posedge reset_reset)
        if (reset_reset) db_q <= 1'b0;
        else             db_q <= db_d;
    assign irq = db_q;
`else
    logic db_q;
    assign db_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (state_q == CLEAR) begin
            clr_d = clr_q + 1'b1;
            if (clr_q == AW'(DEPTH - 2)) begin
                state_d = READY;
                clr_d   = '0;
            end
        end else if (ctrl_wr && in_bridge_slave_writedata[0]) begin
            state_d = CLEAR;
        end
        wait_d   = state_d == CLEAR;
        vld_d[0] = acc_rd;
        dat_d[0] = !acc_rd ? 32'd0 : is_ctrl ? {30'd0, db_q, state_q == CLEAR} : mem[idx];
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_q   <= '0;
            wait_q  <= 1'b1;
            vld_q   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            wait_q  <= wait_d;
            vld_q   <= vld_d;
            for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= dat_d[i];
        end
    end

    // The array has no reset; the clear engine is what zeroes it
    always_ff @(posedge clk_clk) begin
        if (state_q == CLEAR)
            mem[clr_q] <= '0;
        else if (acc_wr && !is_ctrl)
            for (int b = 0; b < 4; b++)
                if (in_bridge_slave_byteenable[b]) mem[idx][8*b +: 8] <= in_bridge_slave_writedata[8*b +: 8];
    end

    assign in_bridge_slave_waitrequest   = wait_q;
    assign in_bridge_slave_readdata      = dat_q[READ_LATENCY-1];
    assign in_bridge_slave_readdatavalid = vld_q[READ_LATENCY-1];
endmodule
